// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the fetch PC and issues req/ack fetches to instruction memory.
// Delivers instructions to decode over valid/ready, with a one-entry skid buffer and redirect flush.
module fetch_stage #(
  parameter int unsigned          ADDRESS_SIZE     = 32,
  parameter int unsigned          INSTRUCTION_SIZE = 4,
  parameter int unsigned          DATA_WIDTH       = 32,
  parameter logic [ADDRESS_SIZE-1:0] RESET_VECTOR  = 32'h0
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    redirect_valid,
  input  logic [ADDRESS_SIZE-1:0] redirect_pc,
  output logic                    imem_req,
  output logic [ADDRESS_SIZE-1:0] imem_addr,
  input  logic                    imem_ack,
  input  logic [DATA_WIDTH-1:0]   imem_rdata,
  output logic                    if_valid,
  output logic [ADDRESS_SIZE-1:0] if_pc,
  output logic [DATA_WIDTH-1:0]   if_instr,
  input  logic                    id_ready,
  output logic [ADDRESS_SIZE-1:0] fetch_pc
);

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    STALL = 2'd1,
    DROP  = 2'd2
  } state_e;

  state_e state_q, state_d;

  logic                    req_en_q;
  logic [ADDRESS_SIZE-1:0] fetch_pc_q, fetch_pc_d;
  logic [ADDRESS_SIZE-1:0] target_q, target_d;
  logic                    if_valid_q, if_valid_d;
  logic [ADDRESS_SIZE-1:0] if_pc_q, if_pc_d;
  logic [DATA_WIDTH-1:0]   if_instr_q, if_instr_d;
  logic                    skid_valid_q, skid_valid_d;
  logic [ADDRESS_SIZE-1:0] skid_pc_q, skid_pc_d;
  logic [DATA_WIDTH-1:0]   skid_instr_q, skid_instr_d;

  logic                    ack;
  logic                    drain;
  logic                    slot_free;
  logic [ADDRESS_SIZE-1:0] redirect_tgt;
  logic [ADDRESS_SIZE-1:0] pc_inc;

  // Late acks after reset or while idle are ignored by qualifying with our own request.
  assign ack          = imem_ack && imem_req;
  assign drain        = if_valid_q && id_ready;
  assign slot_free    = !if_valid_q || id_ready;
  assign redirect_tgt = redirect_pc & ~ADDRESS_SIZE'(3);
  assign pc_inc       = fetch_pc_q + ADDRESS_SIZE'(INSTRUCTION_SIZE);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= FETCH;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    if (redirect_valid) begin
      case (state_q)
        FETCH:   if (imem_req && !ack) state_d = DROP;
        STALL:   state_d = FETCH;
        // An ack arriving alongside the redirect closes the handshake, so no further drop is needed.
        DROP:    if (ack) state_d = FETCH;
        default: state_d = FETCH;
      endcase
    end else begin
      case (state_q)
        FETCH:   if (ack && !slot_free) state_d = STALL;
        STALL:   if (id_ready) state_d = FETCH;
        DROP:    if (ack) state_d = FETCH;
        default: state_d = FETCH;
      endcase
    end
  end

  // Output logic
  always_comb begin
    imem_req  = req_en_q && (state_q != STALL);
    imem_addr = fetch_pc_q;
  end

  // Datapath next-state
  always_comb begin
    fetch_pc_d   = fetch_pc_q;
    target_d     = target_q;
    if_valid_d   = if_valid_q;
    if_pc_d      = if_pc_q;
    if_instr_d   = if_instr_q;
    skid_valid_d = skid_valid_q;
    skid_pc_d    = skid_pc_q;
    skid_instr_d = skid_instr_q;

    if (redirect_valid) begin
      if_valid_d   = 1'b0;
      skid_valid_d = 1'b0;
      case (state_q)
        FETCH: begin
          if (imem_req && !ack) target_d = redirect_tgt;
          else                  fetch_pc_d = redirect_tgt;
        end
        STALL: fetch_pc_d = redirect_tgt;
        DROP: begin
          if (ack) fetch_pc_d = redirect_tgt;
          else     target_d   = redirect_tgt;
        end
        default: fetch_pc_d = redirect_tgt;
      endcase
    end else begin
      case (state_q)
        FETCH: begin
          if (drain) if_valid_d = 1'b0;
          if (ack) begin
            fetch_pc_d = pc_inc;
            if (slot_free) begin
              if_valid_d = 1'b1;
              if_pc_d    = fetch_pc_q;
              if_instr_d = imem_rdata;
            end else begin
              skid_valid_d = 1'b1;
              skid_pc_d    = fetch_pc_q;
              skid_instr_d = imem_rdata;
            end
          end
        end
        STALL: begin
          if (id_ready) begin
            if_valid_d   = skid_valid_q;
            if_pc_d      = skid_pc_q;
            if_instr_d   = skid_instr_q;
            skid_valid_d = 1'b0;
          end
        end
        DROP: begin
          if (drain) if_valid_d = 1'b0;
          if (ack)   fetch_pc_d = target_q;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_en_q     <= 1'b0;
      fetch_pc_q   <= RESET_VECTOR;
      target_q     <= '0;
      if_valid_q   <= 1'b0;
      if_pc_q      <= '0;
      if_instr_q   <= '0;
      skid_valid_q <= 1'b0;
      skid_pc_q    <= '0;
      skid_instr_q <= '0;
    end else begin
      req_en_q     <= 1'b1;
      fetch_pc_q   <= fetch_pc_d;
      target_q     <= target_d;
      if_valid_q   <= if_valid_d;
      if_pc_q      <= if_pc_d;
      if_instr_q   <= if_instr_d;
      skid_valid_q <= skid_valid_d;
      skid_pc_q    <= skid_pc_d;
      skid_instr_q <= skid_instr_d;
    end
  end

  assign if_valid = if_valid_q;
  assign if_pc    = if_pc_q;
  assign if_instr = if_instr_q;
  assign fetch_pc = fetch_pc_q;

`ifndef SYNTHESIS
  a_req_held : assert property (@(posedge clk) disable iff (!rst_n)
    imem_req && !imem_ack |=> imem_req && $stable(imem_addr));
  a_out_stable : assert property (@(posedge clk) disable iff (!rst_n)
    if_valid && !id_ready && !redirect_valid |=> if_valid && $stable(if_pc) && $stable(if_instr));
`endif

endmodule
